// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with its own bit-period counter, re-aligned
// on every start-bit falling edge; emits rx_done / frame_error strobes.
module uart_receiver #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_WIDTH    = 13
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_done,
    output logic                  frame_error,
    output logic                  rx_busy
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] HALF_M1 = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_M1 = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;
    logic                  sync1_q, rx_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            rx_s    <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    if (idx_q == LAST_IDX) state_d = STOP;
                    else idx_d = idx_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    data_d  = rx_s ? shift_q : data_q;
                    done_d  = rx_s;
                    ferr_d  = !rx_s;
                    state_d = rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // a stuck-low line must not restart frames until it returns high
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data     = data_q;
    assign rx_done     = done_q;
    assign frame_error = ferr_q;
    assign rx_busy     = (state_q != IDLE);
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive stage; the downstream counterpart to the transmitter system. It consumes the serial line driven by `tx` and returns parallel bytes.
- Frame format: 8N1, LSB first, idle-high line.
- It carries its own bit-period counter, so no external baud tick is used. The counter re-aligns to every start-bit falling edge, which tolerates small clock/baud mismatch against the transmitter.
- Outputs a parallel word with a one-cycle `rx_done` strobe, plus a framing-error strobe. Intended for loopback against the transmitter system and for board-level RX from a host.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- CLKS_PER_BIT, 5208, clock cycles per bit period (50 MHz / 9600 baud). Must be ≥ 4 and even.
- CNT_WIDTH, 13, bit-period counter width. Must satisfy 2^CNT_WIDTH > CLKS_PER_BIT.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial input line; asynchronous to clock; idle = 1.
- rx_data  output  DATA_WIDTH  last correctly received word; holds its value until the next good frame.
- rx_done  output  1  one-cycle pulse when a good frame completes.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- **Synchroniser.**
  - `rx` passes through a 2-flop synchroniser; both flops reset to 1.
  - All FSM decisions use the second flop's output, rx_s.
- **Reset (asynchronous).**
  - State = IDLE; counter = 0; bit index = 0; shift register = 0.
  - rx_data = 0, rx_done = 0, frame_error = 0, rx_busy = 0.
  - Reset asserted mid-frame abandons the frame: no rx_done, no frame_error.
- **Counter.** Counts clock cycles within the current bit. It is cleared on every state transition and at every data-bit sample.
- **States:**
  - IDLE:
    - rx_s == 0 → START, counter cleared.
    - Otherwise stay in IDLE.
  - START: counter increments. When counter == CLKS_PER_BIT/2 − 1 (start-bit midpoint):
    - rx_s == 0 → DATA, counter = 0, bit index = 0.
    - rx_s == 1 → IDLE. The low was a glitch; no outputs pulse.
  - DATA: counter increments. When counter == CLKS_PER_BIT − 1 (mid data bit):
    - Shift register ← {rx_s, shift[DATA_WIDTH−1:1]}, so bits arrive LSB first.
    - Counter = 0.
    - If bit index == DATA_WIDTH − 1 → STOP; else bit index + 1.
  - STOP: counter increments. When counter == CLKS_PER_BIT − 1 (mid stop bit):
    - rx_s == 1:
      - rx_data ← shift register.
      - rx_done = 1 for exactly one cycle.
      - → IDLE.
    - rx_s == 0:
      - frame_error = 1 for exactly one cycle.
      - rx_data unchanged.
      - → WAIT_IDLE.
  - WAIT_IDLE:
    - Stay while rx_s == 0, so a break or stuck-low line does not generate repeated frames.
    - rx_s == 1 → IDLE.
- **Timing.**
  - rx_done and frame_error are registered and never high together.
  - Outside the single cycle they pulse, both are 0.
- **Back-to-back frames.** A start bit immediately following a stop bit is accepted: the FSM is back in IDLE by mid stop bit, half a bit before the next falling edge.
- **Latency.** From the rx falling edge to the rx_done pulse is 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles, ±1.
- **No flow control.** rx_data is overwritten by the next good frame; the consumer must capture it on rx_done.

Test Plan (CLKS_PER_BIT = 16 unless noted):
- **Single frame.** Send 0xA5 as 8N1, 16 clk/bit → exactly one rx_done pulse, rx_data = 0xA5, frame_error never high, rx_busy low after the stop bit.
- **Back-to-back frames.** Send 0x00, 0xFF, 0x55 with no idle gap → three rx_done pulses, with rx_data = 0x00, 0xFF, 0x55 in order.
- **Start-bit glitch.** Drive rx low for 4 cycles, then high → no rx_done, no frame_error, FSM returns to IDLE; a following 0x3C frame is received correctly.
- **Framing error.** Send 0x81 with stop bit = 0, held low for 40 cycles, then high → one frame_error pulse, no rx_done, rx_data keeps its previous value, no second frame_error. A subsequent 0x42 frame → rx_data = 0x42.
- **Reset mid-frame.** Assert reset during data bit 3 of 0xC3 → all outputs 0 immediately, no rx_done. A clean 0x99 frame after release → rx_data = 0x99.
- **Loopback with baud mismatch.** Drive the transmitter system's tx output into rx, with CLKS_PER_BIT = 5208 against the transmitter's ~5209-cycle bit period. Send 0x00 through 0xFF → every rx_done matches tx data_in, zero frame errors.
